// File: rtl/updown_count_tracker_pkg.sv
// Shared types and constants for the up/down counter tracker.
// Step classes describe one counter transition; DIR_* encode the direction bit.
package updown_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  typedef enum logic [1:0] {STEP_UP, STEP_DN, STEP_BAD} step_t;

  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DN      = 1'b1;
  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  // Direction bit implied by a legal step; only meaningful for STEP_UP/STEP_DN.
  function automatic logic step_dir(step_t s);
    return (s == STEP_DN) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/updown_count_tracker_if.sv
// Sample/result bundle between the counter side and the tracker.
// The master drives the counter samples; the slave (tracker) returns status.
interface updown_count_tracker_if;

  logic       en;
  logic [3:0] q_in;
  logic       dir;
  logic       locked;
  logic       err;
  logic       dir_chg;
  logic [3:0] err_cnt;

  modport master (
    output en, q_in,
    input  dir, locked, err, dir_chg, err_cnt
  );

  modport slave (
    input  en, q_in,
    output dir, locked, err, dir_chg, err_cnt
  );

endinterface

// File: rtl/updown_count_tracker_step_classify.sv
// Classifies one counter transition as up, down or illegal using modulo-16 delta.
// Wrap-around (15->0, 0->15) falls out of the 4-bit subtraction naturally.
module updown_step_classify
  import updown_pkg::*;
(
  input  logic [3:0] i_prev,
  input  logic [3:0] i_cur,
  output step_t      o_step
);

  logic [3:0] w_delta;

  assign w_delta = i_cur - i_prev;

  always_comb begin
    o_step = STEP_BAD;
    if (w_delta == 4'd1) begin
      o_step = STEP_UP;
    end else if (w_delta == 4'd15) begin
      o_step = STEP_DN;
    end
  end

endmodule

// File: rtl/updown_count_tracker.sv
// Recovers the up/down direction of a 4-bit counter from its sampled Q values,
// locking after LOCK_STEPS consistent steps and counting illegal jumps while locked.
module updown_count_tracker
  import updown_pkg::*;
#(
  parameter int LOCK_STEPS = 2
)(
  input logic                    clk,
  input logic                    rst,
  updown_count_tracker_if.slave  bus
);

  localparam logic [2:0] LOCK_RUN = 3'(LOCK_STEPS);

  state_t     r_state,  w_stateNext;
  logic [3:0] r_prev,   w_prevNext;
  logic [2:0] r_run,    w_runNext;
  logic       r_cand,   w_candNext;
  logic       r_dir,    w_dirNext;
  logic       r_locked, w_lockedNext;
  logic       r_err,    w_errNext;
  logic       r_dirChg, w_dirChgNext;
  logic [3:0] r_errCnt, w_errCntNext;

  step_t      w_step;
  logic       w_stepDir;

  updown_step_classify u_classify (
    .i_prev (r_prev),
    .i_cur  (bus.q_in),
    .o_step (w_step)
  );

  assign w_stepDir = step_dir(w_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prev   <= 4'd0;
      r_run    <= 3'd0;
      r_cand   <= DIR_UP;
      r_dir    <= DIR_UP;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_dirChg <= 1'b0;
      r_errCnt <= 4'd0;
    end else begin
      r_state  <= w_stateNext;
      r_prev   <= w_prevNext;
      r_run    <= w_runNext;
      r_cand   <= w_candNext;
      r_dir    <= w_dirNext;
      r_locked <= w_lockedNext;
      r_err    <= w_errNext;
      r_dirChg <= w_dirChgNext;
      r_errCnt <= w_errCntNext;
    end
  end

  // Pulses default low, so a cycle with en low clears them while all else holds.
  always_comb begin
    w_stateNext  = r_state;
    w_prevNext   = r_prev;
    w_runNext    = r_run;
    w_candNext   = r_cand;
    w_dirNext    = r_dir;
    w_lockedNext = r_locked;
    w_errNext    = 1'b0;
    w_dirChgNext = 1'b0;
    w_errCntNext = r_errCnt;

    if (bus.en) begin
      w_prevNext = bus.q_in;
      case (r_state)
        IDLE: begin
          w_runNext   = 3'd0;
          w_stateNext = ACQ;
        end
        ACQ: begin
          if (w_step == STEP_BAD) begin
            w_runNext = 3'd0;
          end else begin
            if (r_run == 3'd0 || w_stepDir == r_cand) begin
              w_runNext = r_run + 3'd1;
            end else begin
              w_runNext = 3'd1;
            end
            w_candNext = w_stepDir;
            if (w_runNext == LOCK_RUN) begin
              w_stateNext  = LOCK;
              w_lockedNext = 1'b1;
              w_dirNext    = w_stepDir;
            end
          end
        end
        LOCK: begin
          if (w_step == STEP_BAD) begin
            w_errNext    = 1'b1;
            w_lockedNext = 1'b0;
            w_runNext    = 3'd0;
            w_stateNext  = ACQ;
            if (r_errCnt != ERR_CNT_MAX) begin
              w_errCntNext = r_errCnt + 4'd1;
            end
          end else if (w_stepDir != r_dir) begin
            w_dirNext    = w_stepDir;
            w_candNext   = w_stepDir;
            w_dirChgNext = 1'b1;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  assign bus.dir     = r_dir;
  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.dir_chg = r_dirChg;
  assign bus.err_cnt = r_errCnt;

endmodule

// File: tb/tb_updown_count_tracker.sv
// Self-checking bench: a step-history model checked every cycle, plus directed
// scenarios with literal expectations for lock, wrap, reversal, errors and gaps.
module tb_updown_count_tracker;

  localparam int LOCK_STEPS = 2;

  logic clk;
  logic rst;

  updown_count_tracker_if bus ();

  updown_count_tracker #(.LOCK_STEPS(LOCK_STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit mStarted = 0;
  bit mLocked  = 0;
  bit mDir     = 0;
  bit mErr     = 0;
  bit mChg     = 0;
  int mPrev    = 0;
  int mErrCnt  = 0;
  int steps[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of signed steps since acquisition began; lock once the
  // trailing LOCK_STEPS entries are the same legal direction.
  always @(posedge clk) begin
    int  d;
    int  s;
    bit  same;
    if (rst) begin
      mStarted = 0; mLocked = 0; mDir = 0; mErr = 0; mChg = 0;
      mPrev = 0; mErrCnt = 0;
      steps.delete();
    end else if (bus.en) begin
      mErr = 0;
      mChg = 0;
      if (!mStarted) begin
        mStarted = 1;
        steps.delete();
      end else begin
        d = (int'(bus.q_in) - mPrev + 16) % 16;
        s = (d == 1) ? 1 : (d == 15) ? -1 : 0;
        if (mLocked) begin
          if (s == 0) begin
            mErr = 1;
            mErrCnt = (mErrCnt >= 15) ? 15 : mErrCnt + 1;
            mLocked = 0;
            steps.delete();
          end else if ((s < 0) != mDir) begin
            mDir = (s < 0);
            mChg = 1;
          end
        end else if (s == 0) begin
          steps.delete();
        end else begin
          steps.push_back(s);
          if (steps.size() >= LOCK_STEPS) begin
            same = 1;
            for (int i = 1; i <= LOCK_STEPS; i++) begin
              if (steps[steps.size() - i] != s) same = 0;
            end
            if (same) begin
              mLocked = 1;
              mDir = (s < 0);
              steps.delete();
            end
          end
        end
      end
      mPrev = int'(bus.q_in);
    end else begin
      mErr = 0;
      mChg = 0;
    end
    #1;
    cmp("model_locked", int'(bus.locked), int'(mLocked));
    cmp("model_err", int'(bus.err), int'(mErr));
    cmp("model_dir_chg", int'(bus.dir_chg), int'(mChg));
    cmp("model_err_cnt", int'(bus.err_cnt), mErrCnt);
    if (mLocked) cmp("model_dir", int'(bus.dir), int'(mDir));
  end

  task automatic applyStimulus(input logic r, input logic e, input int q);
    rst      = r;
    bus.en   = e;
    bus.q_in = 4'(q);
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int expLocked, input int expDir,
                             input int expErr, input int expChg, input int expCnt);
    cmp({name, "_locked"}, int'(bus.locked), expLocked);
    cmp({name, "_dir"}, int'(bus.dir), expDir);
    cmp({name, "_err"}, int'(bus.err), expErr);
    cmp({name, "_dir_chg"}, int'(bus.dir_chg), expChg);
    cmp({name, "_err_cnt"}, int'(bus.err_cnt), expCnt);
  endtask

  initial begin
    int v;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.q_in = 4'd0;

    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 3);  checkOutput("up_s3", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4);  checkOutput("up_s4", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5);  checkOutput("up_lock", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 6);  checkOutput("up_hold", 1, 0, 0, 0, 0);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 14); checkOutput("wrap_s14", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 15); checkOutput("wrap_s15", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0);  checkOutput("wrap_lock", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1);  checkOutput("wrap_hold", 1, 0, 0, 0, 0);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 9);
    applyStimulus(0, 1, 8);
    applyStimulus(0, 1, 7);  checkOutput("dn_lock", 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 8);  checkOutput("dn_reverse", 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 9);  checkOutput("dn_after", 1, 0, 0, 0, 0);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 3);
    applyStimulus(0, 1, 4);
    applyStimulus(0, 1, 5);  checkOutput("jump_pre", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 9);  checkOutput("jump_err", 0, 0, 1, 0, 1);
    applyStimulus(0, 1, 10); checkOutput("relock_s10", 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 11); checkOutput("relock", 1, 0, 0, 0, 1);

    v = 11;
    for (int k = 0; k < 17; k++) begin
      v = (v + 5) % 16; applyStimulus(0, 1, v);
      v = (v + 1) % 16; applyStimulus(0, 1, v);
      v = (v + 1) % 16; applyStimulus(0, 1, v);
    end
    checkOutput("sat_locked", 1, 0, 0, 0, 15);
    v = (v + 5) % 16;
    applyStimulus(0, 1, v);  checkOutput("sat_hold", 0, 0, 1, 0, 15);
    applyStimulus(1, 1, 3);  checkOutput("rst_priority", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4);  checkOutput("idle_first", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5);  checkOutput("idle_second", 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 6);  checkOutput("idle_lock", 1, 0, 0, 0, 0);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 5);
    applyStimulus(0, 1, 6);
    applyStimulus(0, 1, 7);  checkOutput("gap_pre", 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 9);  checkOutput("gap_1", 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 10); checkOutput("gap_2", 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 12); checkOutput("gap_3", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 8);  checkOutput("gap_resume", 1, 0, 0, 0, 0);

    applyStimulus(0, 0, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_count_tracker.md
# updown_count_tracker

- Receive-side checker for the 4-bit up/down T-flip-flop counter.
- Samples the counter's Q[3:0] each enabled cycle and recovers the direction input x (0 = up, 1 = down) from successive values.
- Declares lock after a run of consistent steps; flags illegal jumps and keeps a saturating error count.
- Sits downstream of the counter, sampling on the opposite clock edge from the counter's negedge update.

## Interface
- LOCK_STEPS, 2: consecutive same-direction legal steps required to assert lock (1..7).
- clk  in  1  clock; all state updates on posedge (counter updates on negedge, giving half-cycle setup).
- rst  in  1  reset, synchronous, active-high.
- en  in  1  sample strobe; when low the block holds all state and pulses are 0.
- q_in  in  4  counter value Q[3:0].
- dir  out  1  recovered direction, 0 = up, 1 = down; meaningful only while locked.
- locked  out  1  tracker locked to a legal step sequence.
- err  out  1  one-cycle pulse: illegal step seen while locked.
- dir_chg  out  1  one-cycle pulse: legal direction reversal seen while locked.
- err_cnt  out  4  count of err pulses, saturating at 15.

## Operation
- Step classification: delta = (q_in − prev) mod 16.
  - delta 1 → UP.
  - delta 15 → DOWN.
  - Any other value, including 0, → BAD.
- Wrap-around is legal: 15→0 is UP, 0→15 is DOWN.
- prev is updated to q_in on every enabled cycle in all states except during reset.
- States: IDLE, ACQ, LOCK.
- IDLE, on en:
  - Capture prev; run = 0.
  - Go to ACQ; no outputs change.
- ACQ, on en:
  - BAD → run = 0.
  - UP/DOWN with run == 0 or matching cand → cand = step, run += 1.
  - UP/DOWN opposite to cand → cand = step, run = 1.
  - When run reaches LOCK_STEPS → go to LOCK, locked = 1, dir = cand.
  - No err pulses in ACQ.
- LOCK, on en:
  - Step matches dir → stay, no pulse.
  - Opposite legal step → dir flips, dir_chg = 1 for one cycle, stay locked.
  - BAD → err = 1 for one cycle, err_cnt += 1 (holds at 15), locked = 0, run = 0, go to ACQ.
- Reset values: state IDLE, prev 0, run 0, cand 0; dir 0, locked 0, err 0, dir_chg 0, err_cnt 0.
- rst takes priority over en in the same cycle; reset mid-lock clears err_cnt and lock.
- en low in any state: state, prev, run, dir and err_cnt hold; err and dir_chg read 0.

## Timing
- All outputs registered. A sample taken at posedge N is reflected on outputs from posedge N until posedge N+1.
- Pulses last exactly one cycle, and only on cycles where en was high at the edge.
- Lock latency, en continuously high from reset release:
  - First sample enters ACQ.
  - locked rises after sample LOCK_STEPS+1, i.e. on the 3rd enabled edge with the default LOCK_STEPS = 2.
- Loss of lock is same-edge as err: locked falls on the edge where err rises.
- Relock needs LOCK_STEPS further legal steps; the BAD sample itself serves as the new prev.

## Structure
- Shared package updown_pkg holds:
  - State enum {IDLE, ACQ, LOCK}.
  - Constants DIR_UP = 0, DIR_DN = 1.
  - Step-class enum {STEP_UP, STEP_DN, STEP_BAD}.
  - ERR_CNT_MAX = 15.
- One sub-module, updown_step_classify: combinational, prev[3:0] and cur[3:0] in, step class out.
- Top holds the FSM, run counter (3 bits), prev register and output registers.

## Test plan
- Reset, then en = 1 with q_in 3,4,5,6:
  - locked = 1 after the edge sampling 5, dir = 0.
  - No err; err_cnt = 0.
- Up-count wrap, q_in 14,15,0,1:
  - Lock after 0, dir = 0.
  - 15→0 and 0→1 accepted without err.
- Locked down (q_in 9,8,7), then 8:
  - dir_chg pulses one cycle, dir = 0, locked stays 1.
- Locked up, then jump 5→9:
  - err pulse, locked = 0, err_cnt = 1.
  - Then 10,11 → relock with dir = 0.
- Repeated illegal jumps (17 lock/err cycles):
  - err_cnt saturates at 15.
  - rst = 1 with en = 1 in the same cycle → all outputs 0, state IDLE.
- Locked up at q_in = 7, then en low for 3 cycles while q_in changes to 12:
  - Nothing changes during the gap.
  - First en-high sample of 8 is a legal UP step with no err.
